wb_regfile: RTL

//   Consumer end of the write-back path: architectural register file plus pending-write scoreboard.

---
 rtl/wb_regfile.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - architectural register file with write-back bypass and pending-write scoreboard
//
// Purpose
//   Consumer end of the write-back path. Holds NREG architectural registers,
//   commits the write-back result each cycle and forwards it to same-cycle
//   reads. A small saturating counter per register tracks how many issued
//   writes to that register have not yet retired; decode uses the resulting
//   stall flag to avoid read-after-write hazards.
//
// Ports
//   clk        in   1      clock, all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   issue_en   in   1      decode issues an instruction that will retire to issue_dst
//   issue_dst  in   AW     destination register of the issuing instruction
//   wb_retire  in   1      an instruction counted at issue retires this cycle
//   wb_en      in   1      retiring instruction writes (0 = squashed, count still released)
//   wb_dst     in   AW     destination of the retiring instruction
//   WB         in   WIDTH  write-back data
//   rd_addr1   in   AW     source register 1
//   rd_need1   in   1      source 1 is used by the decoding instruction
//   rd_addr2   in   AW     source register 2
//   rd_need2   in   1      source 2 is used by the decoding instruction
//   rd_data1   out  WIDTH  source 1 data, combinational, with write-back bypass
//   rd_data2   out  WIDTH  source 2 data, combinational, with write-back bypass
//   stall      out  1      combinational RAW hazard on either used source
//   busy       out  1      registered: some pending counter is nonzero
//   err        out  1      registered sticky: counter overflow or underflow seen

module wb_regfile #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_dst,
    input  logic             wb_retire,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_dst,
    input  logic [WIDTH-1:0] WB,
    input  logic [AW-1:0]    rd_addr1,
    input  logic             rd_need1,
    input  logic [AW-1:0]    rd_addr2,
    input  logic             rd_need2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             stall,
    output logic             busy,
    output logic             err
);

    localparam logic [CNTW-1:0] PEND_MAX  = '1;
    localparam logic [CNTW-1:0] PEND_ZERO = '0;
    localparam logic [CNTW-1:0] PEND_ONE  = CNTW'(1);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [CNTW-1:0]  pend_q [NREG];
    logic [CNTW-1:0]  pend_d [NREG];
    logic             busy_q, busy_d;
    logic             err_q,  err_d;

    // Per-register issue / retire strobes decoded from the two address ports.
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_v;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_v[r] = issue_en  && (issue_dst == AW'(r));
            dec_v[r] = wb_retire && (wb_dst    == AW'(r));
        end
    end

    // Counter next state. Issue and retire to the same register cancel out.
    // At the limits the counter saturates instead of wrapping, and the event
    // is latched in err so a bookkeeping bug upstream is never silent.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        busy_d = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            case ({inc_v[r], dec_v[r]})
                2'b10: begin
                    if (pend_q[r] == PEND_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d[r] = pend_q[r] + PEND_ONE;
                    end
                end
                2'b01: begin
                    if (pend_q[r] == PEND_ZERO) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d[r] = pend_q[r] - PEND_ONE;
                    end
                end
                default: begin
                end
            endcase
            busy_d = busy_d | (pend_d[r] != PEND_ZERO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // Register array write port. The retire strobe alone releases the
    // counter; only a non-squashed retire touches the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wb_retire && wb_en) begin
            regs_q[wb_dst] <= WB;
        end
    end

    // Read side: bypass and hazard detection.
    logic hit1, hit2;
    logic byp1, byp2;
    logic haz1, haz2;

    always_comb begin
        hit1 = wb_retire && (wb_dst == rd_addr1);
        hit2 = wb_retire && (wb_dst == rd_addr2);
        byp1 = hit1 && wb_en;
        byp2 = hit2 && wb_en;

        rd_data1 = byp1 ? WB : regs_q[rd_addr1];
        rd_data2 = byp2 ? WB : regs_q[rd_addr2];

        // A retire to the source releases one pending write this cycle. If
        // that was the last one the value is already final (bypassed, or the
        // old register contents when squashed); a younger outstanding write
        // keeps the hazard alive.
        haz1 = rd_need1 && (pend_q[rd_addr1] > (hit1 ? PEND_ONE : PEND_ZERO));
        haz2 = rd_need2 && (pend_q[rd_addr2] > (hit2 ? PEND_ONE : PEND_ZERO));

        stall = haz1 | haz2;
    end

    assign busy = busy_q;
    assign err  = err_q;

endmodule
